// File: rtl/serial_word_loader.sv
// serial_word_loader
//   Bit-serial to parallel deserializer feeding a WIDTH-bit register.
//   Bits are accepted one per bit_valid/bit_ready handshake into a shift
//   buffer. A completed word moves into an output buffer, which is
//   presented on word_out/word_valid. The next word may assemble while
//   the previous one waits for the consumer.
//
// Ports
//   clk        in   rising-edge system clock
//   reset      in   asynchronous active-high reset
//   clear      in   synchronous abort of the partially assembled word
//   bit_in     in   serial data bit
//   bit_valid  in   bit_in is valid this cycle
//   bit_ready  out  loader can accept a bit this cycle
//   word_out   out  WIDTH-bit word from the output buffer
//   word_valid out  word_out holds an unconsumed word
//   word_ready in   consumer accepts word_out this cycle
//   load       out  word_valid & word_ready (downstream register load)
module serial_word_loader #(
    parameter int WIDTH     = 16,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             load
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_TOP  = CW'(WIDTH - 1);

    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] shreg_r;
    logic [WIDTH-1:0] obuf_r;
    logic             word_valid_r;

    logic             full_s;
    logic             xfer_s;
    logic             accept_s;
    logic             consume_s;
    logic             bit_ready_s;
    logic [CW-1:0]    wr_idx_s;
    logic [CW-1:0]    cnt_nxt_s;
    logic [WIDTH-1:0] shreg_nxt_s;

    assign full_s      = (cnt_r == CNT_FULL);
    // clear blocks acceptance so a bit presented with clear is dropped.
    assign bit_ready_s = ~full_s & ~clear;
    assign accept_s    = bit_valid & bit_ready_s;
    assign consume_s   = word_valid_r & word_ready;
    // A full shift buffer moves out when the output buffer is empty or
    // being consumed on this same edge (no bubble).
    assign xfer_s      = full_s & (~word_valid_r | word_ready);

    // Bit position written by the next accepted bit.
    always_comb begin
        if (LSB_FIRST) begin
            wr_idx_s = cnt_r;
        end else begin
            wr_idx_s = CNT_TOP - cnt_r;
        end
    end

    // Shift buffer next value: decoded single-bit write on accept.
    always_comb begin
        shreg_nxt_s = shreg_r;
        for (int i = 0; i < WIDTH; i++) begin
            if (accept_s && (wr_idx_s == CW'(i))) begin
                shreg_nxt_s[i] = bit_in;
            end else begin
                shreg_nxt_s[i] = shreg_r[i];
            end
        end
    end

    // Bit counter next value; a full buffer ignores clear until it transfers.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (xfer_s) begin
            cnt_nxt_s = '0;
        end else if (full_s) begin
            cnt_nxt_s = cnt_r;
        end else if (clear) begin
            cnt_nxt_s = '0;
        end else if (accept_s) begin
            cnt_nxt_s = cnt_r + CW'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Assembly state: counter and shift buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r   <= '0;
            shreg_r <= '0;
        end else begin
            cnt_r   <= cnt_nxt_s;
            shreg_r <= shreg_nxt_s;
        end
    end

    // Output buffer and its valid flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            obuf_r       <= '0;
            word_valid_r <= 1'b0;
        end else if (xfer_s) begin
            obuf_r       <= shreg_r;
            word_valid_r <= 1'b1;
        end else if (consume_s) begin
            obuf_r       <= obuf_r;
            word_valid_r <= 1'b0;
        end else begin
            obuf_r       <= obuf_r;
            word_valid_r <= word_valid_r;
        end
    end

    assign bit_ready  = bit_ready_s;
    assign word_out   = obuf_r;
    assign word_valid = word_valid_r;
    // word_valid_r is held low by reset, so load cannot fire during reset.
    assign load       = consume_s;

endmodule

// File: tb/tb_serial_word_loader.sv
// Self-checking bench for serial_word_loader: directed scenarios on an
// LSB-first and an MSB-first instance, plus a randomized soak checked
// against a bit-queue reference model.
module tb_serial_word_loader;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         l_clear, l_bit_in, l_bit_valid, l_bit_ready;
    logic         l_word_valid, l_word_ready, l_load;
    logic [W-1:0] l_word_out;
    logic         m_clear, m_bit_in, m_bit_valid, m_bit_ready;
    logic         m_word_valid, m_word_ready, m_load;
    logic [W-1:0] m_word_out;

    int checks = 0;
    int errors = 0;

    serial_word_loader #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .reset(reset), .clear(l_clear), .bit_in(l_bit_in),
        .bit_valid(l_bit_valid), .bit_ready(l_bit_ready), .word_out(l_word_out),
        .word_valid(l_word_valid), .word_ready(l_word_ready), .load(l_load)
    );

    serial_word_loader #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .reset(reset), .clear(m_clear), .bit_in(m_bit_in),
        .bit_valid(m_bit_valid), .bit_ready(m_bit_ready), .word_out(m_word_out),
        .word_valid(m_word_valid), .word_ready(m_word_ready), .load(m_load)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Sends w bit 0 first on consecutive cycles to the LSB-first instance.
    task automatic send_word_l(input logic [W-1:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            l_bit_valid = 1'b1;
            l_bit_in    = w[i];
            settle();
            checks++;
            if (l_bit_ready !== 1'b1) begin
                errors++;
                $display("FAIL send_ready bit %0d: got %b want 1", i, l_bit_ready);
            end
            tick();
        end
        l_bit_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        l_clear = 1'b0; l_bit_in = 1'b0; l_bit_valid = 1'b0; l_word_ready = 1'b1;
        m_clear = 1'b0; m_bit_in = 1'b0; m_bit_valid = 1'b0; m_word_ready = 1'b1;
        #12;
        checks++;
        if ({l_word_valid, l_load, l_bit_ready, l_word_out} !== {3'b001, 16'h0000}) begin
            errors++;
            $display("FAIL reset_lsb: got v=%b ld=%b rdy=%b out=%h want v=0 ld=0 rdy=1 out=0000",
                     l_word_valid, l_load, l_bit_ready, l_word_out);
        end
        checks++;
        if ({m_word_valid, m_load, m_bit_ready, m_word_out} !== {3'b001, 16'h0000}) begin
            errors++;
            $display("FAIL reset_msb: got v=%b ld=%b rdy=%b out=%h want v=0 ld=0 rdy=1 out=0000",
                     m_word_valid, m_load, m_bit_ready, m_word_out);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_lsb();
        bit s [W] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        l_word_ready = 1'b1;
        for (int i = 0; i < W; i++) begin
            l_bit_valid = 1'b1;
            l_bit_in    = s[i];
            tick();
        end
        l_bit_valid = 1'b0;
        settle();
        checks++;
        if ({l_bit_ready, l_word_valid} !== 2'b00) begin
            errors++;
            $display("FAIL lsb_last_edge: got rdy=%b v=%b want rdy=0 v=0", l_bit_ready, l_word_valid);
        end
        tick();
        checks++;
        if ({l_word_valid, l_load, l_word_out} !== {2'b11, 16'h800D}) begin
            errors++;
            $display("FAIL lsb_word: got v=%b ld=%b out=%h want v=1 ld=1 out=800d",
                     l_word_valid, l_load, l_word_out);
        end
        tick();
        checks++;
        if ({l_word_valid, l_load} !== 2'b00) begin
            errors++;
            $display("FAIL lsb_one_load: got v=%b ld=%b want v=0 ld=0", l_word_valid, l_load);
        end
    endtask

    task automatic test_basic_msb();
        bit s [W] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        m_word_ready = 1'b1;
        for (int i = 0; i < W; i++) begin
            m_bit_valid = 1'b1;
            m_bit_in    = s[i];
            tick();
        end
        m_bit_valid = 1'b0;
        tick();
        checks++;
        if ({m_word_valid, m_load, m_word_out} !== {2'b11, 16'hB001}) begin
            errors++;
            $display("FAIL msb_word: got v=%b ld=%b out=%h want v=1 ld=1 out=b001",
                     m_word_valid, m_load, m_word_out);
        end
        tick();
        checks++;
        if (m_word_valid !== 1'b0) begin
            errors++;
            $display("FAIL msb_consumed: got v=%b want 0", m_word_valid);
        end
    endtask

    task automatic test_backpressure();
        l_word_ready = 1'b0;
        send_word_l(16'hAAAA, W);
        tick();
        checks++;
        if ({l_word_valid, l_word_out} !== {1'b1, 16'hAAAA}) begin
            errors++;
            $display("FAIL bp_first: got v=%b out=%h want v=1 out=aaaa", l_word_valid, l_word_out);
        end
        send_word_l(16'h5555, W);
        tick();
        tick();
        settle();
        checks++;
        if ({l_bit_ready, l_word_valid, l_load, l_word_out} !== {3'b010, 16'hAAAA}) begin
            errors++;
            $display("FAIL bp_hold: got rdy=%b v=%b ld=%b out=%h want rdy=0 v=1 ld=0 out=aaaa",
                     l_bit_ready, l_word_valid, l_load, l_word_out);
        end
        l_word_ready = 1'b1;
        settle();
        checks++;
        if (l_load !== 1'b1) begin
            errors++;
            $display("FAIL bp_load: got %b want 1", l_load);
        end
        tick();
        l_word_ready = 1'b0;
        settle();
        checks++;
        if ({l_word_valid, l_bit_ready, l_load, l_word_out} !== {3'b110, 16'h5555}) begin
            errors++;
            $display("FAIL bp_swap: got v=%b rdy=%b ld=%b out=%h want v=1 rdy=1 ld=0 out=5555",
                     l_word_valid, l_bit_ready, l_load, l_word_out);
        end
        l_word_ready = 1'b1;
        tick();
        checks++;
        if (l_word_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got v=%b want 0", l_word_valid);
        end
    endtask

    task automatic test_clear();
        l_word_ready = 1'b1;
        send_word_l(16'h007F, 7);
        l_clear     = 1'b1;
        l_bit_valid = 1'b1;
        l_bit_in    = 1'b1;
        settle();
        checks++;
        if (l_bit_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_ready: got %b want 0", l_bit_ready);
        end
        tick();
        l_clear     = 1'b0;
        l_bit_valid = 1'b0;
        send_word_l(16'h1234, W);
        tick();
        checks++;
        if ({l_word_valid, l_load, l_word_out} !== {2'b11, 16'h1234}) begin
            errors++;
            $display("FAIL clear_word: got v=%b ld=%b out=%h want v=1 ld=1 out=1234",
                     l_word_valid, l_load, l_word_out);
        end
        tick();
    endtask

    task automatic test_async_reset();
        l_word_ready = 1'b0;
        send_word_l(16'hC3C3, W);
        tick();
        send_word_l(16'h03FF, 10);
        checks++;
        if (l_word_valid !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: got v=%b want 1", l_word_valid);
        end
        #2;
        reset        = 1'b1;
        l_word_ready = 1'b1;
        #1;
        checks++;
        if ({l_word_valid, l_load, l_bit_ready, l_word_out} !== {3'b001, 16'h0000}) begin
            errors++;
            $display("FAIL areset_now: got v=%b ld=%b rdy=%b out=%h want v=0 ld=0 rdy=1 out=0000",
                     l_word_valid, l_load, l_bit_ready, l_word_out);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        checks++;
        if ({l_word_valid, l_load} !== 2'b00) begin
            errors++;
            $display("FAIL areset_release: got v=%b ld=%b want 0 0", l_word_valid, l_load);
        end
        send_word_l(16'hFFFF, W);
        tick();
        checks++;
        if ({l_word_valid, l_load, l_word_out} !== {2'b11, 16'hFFFF}) begin
            errors++;
            $display("FAIL areset_word: got v=%b ld=%b out=%h want v=1 ld=1 out=ffff",
                     l_word_valid, l_load, l_word_out);
        end
        tick();
    endtask

    // Reference: accepted bits collect in a queue; every W bits form the next
    // expected word (bit k of the stream is word bit k). Every consume must
    // deliver the oldest expected word.
    task automatic test_soak();
        logic [W-1:0] exp_q[$];
        bit           bits_q[$];
        logic [W-1:0] w;
        logic [W-1:0] prev_out;
        bit           prev_hold;
        int           delivered;
        int           loads;
        int           built;
        prev_hold = 1'b0; prev_out = '0;
        delivered = 0; loads = 0; built = 0;
        for (int cyc = 0; cyc < 10100; cyc++) begin
            if (cyc < 10000) begin
                l_bit_valid  = 1'($urandom_range(0, 1));
                l_bit_in     = 1'($urandom_range(0, 1));
                l_word_ready = 1'($urandom_range(0, 1));
            end else begin
                l_bit_valid  = 1'b0;
                l_word_ready = 1'b1;
            end
            settle();
            if (prev_hold) begin
                checks++;
                if (l_word_valid !== 1'b1 || l_word_out !== prev_out) begin
                    errors++;
                    $display("FAIL soak_stable cyc %0d: got v=%b out=%h want v=1 out=%h",
                             cyc, l_word_valid, l_word_out, prev_out);
                end
            end
            if (l_bit_valid && l_bit_ready) begin
                bits_q.push_back(l_bit_in);
                if (bits_q.size() == W) begin
                    for (int i = 0; i < W; i++) w[i] = bits_q[i];
                    bits_q.delete();
                    exp_q.push_back(w);
                    built++;
                end
            end
            if (l_word_valid && l_word_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL soak_extra cyc %0d: got out=%h want no word", cyc, l_word_out);
                end else begin
                    w = exp_q.pop_front();
                    if (l_word_out !== w) begin
                        errors++;
                        $display("FAIL soak_word cyc %0d: got %h want %h", cyc, l_word_out, w);
                    end
                end
                delivered++;
            end
            if (l_load === 1'b1) loads++;
            prev_hold = l_word_valid && !l_word_ready;
            prev_out  = l_word_out;
            tick();
        end
        checks++;
        if (exp_q.size() != 0 || delivered != built || built < 100) begin
            errors++;
            $display("FAIL soak_count: got delivered=%0d pending=%0d want delivered=built=%0d (>=100), pending=0",
                     delivered, exp_q.size(), built);
        end
        checks++;
        if (loads != delivered) begin
            errors++;
            $display("FAIL soak_loads: got %0d want %0d", loads, delivered);
        end
    endtask

    initial begin
        test_reset();
        test_basic_lsb();
        test_basic_msb();
        test_backpressure();
        test_clear();
        test_async_reset();
        test_soak();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_word_loader.md
Name: serial_word_loader

Overview:
- Bit-serial to parallel deserializer that sits directly upstream of the 16-bit Register built from Bit cells.
- Accepts one bit per handshake and assembles WIDTH bits into a word.
- Presents the completed word on word_out and drives load, so the downstream register captures it as out[t+1] = word_out[t].
- Double-buffered: the next word can shift in while the previous word waits for the consumer.

Parameters:
- WIDTH, 16, number of bits per word (>= 2).
- LSB_FIRST, 1, 1 = first accepted bit lands in word bit 0; 0 = first accepted bit lands in word bit WIDTH-1.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous abort: discard the partially assembled word.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_ready  output  1  loader can accept a bit this cycle.
- word_out  output  WIDTH  assembled word from the output buffer; drives the downstream register's in.
- word_valid  output  1  word_out holds an unconsumed word.
- word_ready  input  1  consumer accepts word_out this cycle.
- load  output  1  combinational word_valid & word_ready; drives the downstream register's load.

Behaviour:
- Reset:
  - Clock and reset: one clock (clk); reset is asynchronous and active-high.
  - While reset is high: cnt=0, shift register=0, output buffer=0, word_valid=0.
  - Reset asserted mid-word or with a pending word discards both; no load fires after release.
- State:
  - cnt, range 0..WIDTH, with width clog2(WIDTH+1).
  - shreg[WIDTH-1:0].
  - obuf[WIDTH-1:0], which drives word_out.
  - word_valid flop.
- bit_ready = (cnt != WIDTH) & ~clear. It is combinational from registered state and clear only, and does not depend on bit_valid.
- Bit accept:
  - Condition: bit_valid & bit_ready at the edge.
  - LSB_FIRST=1: bit_in is written into shreg[cnt].
  - LSB_FIRST=0: bit_in is written into shreg[WIDTH-1-cnt].
  - cnt increments by 1.
  - Bits of shreg not yet written hold stale data and are never visible on word_out.
- Transfer:
  - Condition: cnt==WIDTH and (~word_valid | word_ready) at the edge.
  - Effect: obuf<=shreg, word_valid<=1, cnt<=0.
  - Transfer has priority over clear in the same cycle; clear acts on the following partial word.
- Latency:
  - The last bit is sampled at edge E, so cnt==WIDTH after E and bit_ready=0 for that cycle.
  - With the output free, transfer occurs at edge E+1, and word_valid=1 with the new word_out after E+1.
  - Peak throughput is one word per WIDTH+1 cycles.
- Output handshake:
  - word_valid & word_ready at the edge consumes the word; word_valid<=0 unless a transfer occurs on the same edge.
  - On a simultaneous consume and transfer, word_valid stays 1 and obuf takes the new word. There is no bubble and no loss.
  - word_out is stable while word_valid=1 and word_ready=0.
- Backpressure:
  - If cnt==WIDTH and word_valid=1 with word_ready=0, the loader holds and bit_ready stays 0.
  - Both buffers are then full and nothing is dropped.
- Clear:
  - When cnt<WIDTH: cnt<=0 and any bit presented in that cycle is not accepted.
  - obuf and word_valid are untouched.
  - When cnt==WIDTH: the completed word still transfers or waits; clear is ignored.
- load:
  - Asserts only when word_valid=1, and never while reset is high.
  - It is exactly one cycle per consumed word.

Test Plan:
- Basic LSB-first: WIDTH=16, LSB_FIRST=1, word_ready=1, serial bits 1,0,1,1,0,0,0,0,0,0,0,0,0,0,0,1 on consecutive cycles -> word_out=16'h800D, word_valid and load high for exactly one cycle, 2 edges after the first bit's edge + 15.
- MSB-first: LSB_FIRST=0, same bit stream -> word_out=16'hB001.
- Backpressure/double buffer, word_ready=0:
  - First stream 0xAAAA (alternating bits) -> word_valid=1, word_out=16'hAAAA held.
  - Second stream 0x5555 -> fully accepted; then bit_ready=0 and word_out stays 16'hAAAA.
  - Raise word_ready for one cycle -> load=1 consumes 0xAAAA; the same edge transfers 0x5555 and word_valid stays 1; bit_ready=1 the next cycle.
- Clear mid-word:
  - Send 7 bits, pulse clear for one cycle with bit_valid=1 -> that bit is not accepted, cnt=0.
  - Then 16 bits encoding 0x1234 -> word_out=16'h1234, not corrupted by the earlier 7 bits.
- Async reset:
  - Assert reset between clock edges with 10 bits shifted and word_valid=1 -> word_valid=0, word_out=0, bit_ready=1 immediately (no clock needed).
  - After release, a full 16-bit stream for 0xFFFF -> word_out=16'hFFFF.
- Random soak: random bit_valid and word_ready over 10k cycles against a queue model -> every word is delivered in order, with no loss or duplication and load count == words delivered.
